serial_add_ctrl: RTL and testbench

//   Bit-serial N-bit adder controller that sequences one full-adder slice (two halfAdder + OR) over

---
 rtl/serial_add_ctrl_pkg.sv | 19 +
 rtl/serial_add_ctrl_fa.sv | 43 ++++
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// legal WIDTH range and a helper that checks WIDTH against it.
package serial_add_ctrl_pkg;

  // Two-state controller: waiting for a start request, or shifting bits.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // True when the operand width is inside the supported range.
  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder built from two half adders and an OR gate for the
// carry. Purely combinational; the controller uses a single instance.

// Half adder: sum is the XOR and carry is the AND of the two inputs.
module serial_add_ctrl_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  // First stage adds the operand bits, second stage folds in the carry.
  serial_add_ctrl_ha u_ha1 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  serial_add_ctrl_ha u_ha2 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  // At most one of the two stages can generate a carry, so OR is enough.
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder controller. Operands are captured on an
// accepted start, fed LSB first through one full-adder slice for WIDTH
// cycles, and the result is published with a single-cycle done pulse.
//
// Handshake: i_START is a request that is only honoured while the FSM is
// in IDLE (o_BUSY low); the edge on which it is seen in IDLE is the accept
// edge and i_A/i_B are captured there. Requests while o_BUSY is high are
// dropped, not queued. o_DONE is a one-cycle strobe marking the cycle from
// which o_SUM/o_CARRY hold the new result; they then stay stable until the
// next completion or reset. A request in the o_DONE cycle is accepted, so
// with i_START held high a new operation starts every WIDTH+1 cycles.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_SUM,
  output logic             o_CARRY,
  output state_t           dbg_state
);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_err
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  state_t         state;
  state_t         state_next;
  logic           start_accept;
  logic           last_bit;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] sum_final;

  // The single adder slice always looks at the current LSBs and carry.
  serial_add_ctrl_fa u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_c),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Result as it will look once this cycle's sum bit has shifted in.
  assign sum_final = {slice_s, r_s[WIDTH-1:1]};

  // State register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the accept and last-bit strobes.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    last_bit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_START) begin
          start_accept = 1'b1;
          state_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          last_bit   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (start_accept) begin
      r_a   <= i_A;
      r_b   <= i_B;
      r_s   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (state == S_RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_s   <= sum_final;
      r_c   <= slice_c;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Output registers: publish the result and strobe done on the last bit.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_DONE  <= 1'b0;
      o_SUM   <= '0;
      o_CARRY <= 1'b0;
    end else begin
      o_DONE <= last_bit;
      if (last_bit) begin
        o_SUM   <= sum_final;
        o_CARRY <= slice_c;
      end
    end
  end

  assign o_BUSY    = (state == S_RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 scenarios plus an exhaustive
// sweep of a WIDTH=2 instance. Edges are counted from the accept edge (0).
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  int total = 0;
  int bad   = 0;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance.
  logic       start = 1'b0;
  logic [7:0] a_in  = '0;
  logic [7:0] b_in  = '0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;
  state_t     st;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_START   (start),
    .i_A       (a_in),
    .i_B       (b_in),
    .o_BUSY    (busy),
    .o_DONE    (done),
    .o_SUM     (sum),
    .o_CARRY   (carry),
    .dbg_state (st)
  );

  // WIDTH=2 instance.
  logic       start2 = 1'b0;
  logic [1:0] a2     = '0;
  logic [1:0] b2     = '0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       carry2;
  state_t     st2;

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_START   (start2),
    .i_A       (a2),
    .i_B       (b2),
    .o_BUSY    (busy2),
    .o_DONE    (done2),
    .o_SUM     (sum2),
    .o_CARRY   (carry2),
    .dbg_state (st2)
  );

  // Run one WIDTH=8 operation and check timing, busy window and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input string name);
    int done_edge;
    bit busy_bad;
    done_edge = -1;
    busy_bad  = 1'b0;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom);
    if (busy !== 1'b1) busy_bad = 1'b1;
    for (int k = 1; k <= 12 && done_edge < 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_edge = k;
      else if (k < 8 && busy !== 1'b1) busy_bad = 1'b1;
    end
    total++;
    if (busy_bad) begin
      bad++; $display("FAIL %s busy_window: busy dropped before edge 8, required high edges 0..7", name);
    end
    total++;
    if (done_edge != 8) begin
      bad++; $display("FAIL %s done_edge: got %0d required 8", name, done_edge);
    end
    total++;
    if ({carry, sum} !== {ec, es}) begin
      bad++; $display("FAIL %s result: got carry=%b sum=%h required carry=%b sum=%h", name, carry, sum, ec, es);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || {carry, sum} !== {ec, es}) begin
      bad++; $display("FAIL %s after_done: got done=%b carry=%b sum=%h required done=0 carry=%b sum=%h",
                      name, done, carry, sum, ec, es);
    end
  endtask

  // Power-on reset, then an asynchronous reset between edges clears a result.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, carry, sum} !== 11'h000) begin
      bad++; $display("FAIL reset_por: got busy=%b done=%b carry=%b sum=%h required all 0", busy, done, carry, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "reset_preload");
    @(negedge clk); #2;
    start = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, carry, sum} !== 11'h000) begin
      bad++; $display("FAIL reset_async: got busy=%b done=%b carry=%b sum=%h required all 0", busy, done, carry, sum);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, 8'h08, 1'b0, "basic_05_03");
  endtask

  task automatic test_carry();
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "carry_FF_01");
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "carry_FF_FF");
  endtask

  // Start during RUN must be dropped; exactly one done for the first op.
  task automatic test_start_ignored();
    int ndone;
    int done_edge;
    ndone = 0;
    done_edge = -1;
    @(negedge clk);
    start = 1'b1; a_in = 8'h10; b_in = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        start = 1'b1; a_in = 8'h77; b_in = 8'h11;
      end
      @(posedge clk); #1;
      if (k == 3) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (done_edge < 0) done_edge = k;
      end
    end
    total++;
    if (ndone != 1 || done_edge != 8) begin
      bad++; $display("FAIL ignore_start_pulses: got %0d pulses first at edge %0d required 1 at edge 8", ndone, done_edge);
    end
    total++;
    if ({carry, sum} !== 9'h030) begin
      bad++; $display("FAIL ignore_start_result: got carry=%b sum=%h required carry=0 sum=30", carry, sum);
    end
  endtask

  // Reset mid-RUN aborts without done and clears outputs; next op is clean.
  task automatic test_abort();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; a_in = 8'h5A; b_in = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, carry, sum} !== 11'h000) begin
      bad++; $display("FAIL abort_clear: got busy=%b done=%b carry=%b sum=%h required all 0", busy, done, carry, sum);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0 || {carry, sum} !== 9'h000) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles carry=%b sum=%h required 0 and outputs 0", ndone, carry, sum);
    end
    run_op(8'hAA, 8'h55, 8'hFF, 1'b0, "after_abort_AA_55");
  endtask

  // Start held high: second op is accepted in the done cycle of the first,
  // so pulses land WIDTH+1 edges apart.
  task automatic test_back_to_back();
    int edge_q[$];
    logic [8:0] res_q[$];
    @(negedge clk);
    start = 1'b1; a_in = 8'h01; b_in = 8'h01;
    @(posedge clk); #1;
    a_in = 8'h80; b_in = 8'h80;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        edge_q.push_back(k);
        res_q.push_back({carry, sum});
      end
    end
    start = 1'b0;
    total++;
    if (edge_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d pulses required 2", edge_q.size());
    end else begin
      total++;
      if (edge_q[0] != 8 || edge_q[1] != 17) begin
        bad++; $display("FAIL b2b_edges: got %0d,%0d required 8,17", edge_q[0], edge_q[1]);
      end
      total++;
      if (res_q[0] !== 9'h002 || res_q[1] !== 9'h100) begin
        bad++; $display("FAIL b2b_results: got %h,%h required 002,100", res_q[0], res_q[1]);
      end
    end
    repeat (10) @(posedge clk);
  endtask

  // Exhaustive sweep of the WIDTH=2 instance.
  task automatic test_width2();
    logic [2:0] exp_q[$];
    logic [2:0] got;
    int done_edge;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(3'(a) + 3'(b));
        done_edge = -1;
        got = 3'bxxx;
        @(negedge clk);
        start2 = 1'b1; a2 = 2'(a); b2 = 2'(b);
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 1; k <= 6 && done_edge < 0; k++) begin
          @(posedge clk); #1;
          if (done2 === 1'b1) begin
            done_edge = k;
            got = {carry2, sum2};
          end
        end
        total++;
        if (done_edge != 2 || got !== exp_q.pop_front()) begin
          bad++; $display("FAIL w2_%0d_%0d: got edge=%0d {c,s}=%b required edge=2 {c,s}=%b",
                          a, b, done_edge, got, 3'(a) + 3'(b));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_width2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
